// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// the newline byte that ends a locked message, counter width and a
// saturating increment helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    localparam logic [7:0] NEWLINE = 8'h0A;
    localparam int         CNT_W   = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick. When both requests are present
// the requester that did not win last time is chosen. Output is one-hot
// (or zero when nobody requests).
module rr_arbiter2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last_grant,   // 1'b1: requester 1 won last, 1'b0: requester 0
    output logic [1:0] gnt
);

    // Pick one requester, alternating on contention.
    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a single UART transmitter.
// Requester 0 is the CPU, requester 1 the debug monitor. A byte is accepted
// in IDLE, strobed to the UART one cycle later, then the arbiter waits for
// the UART busy flag to rise (bounded by BUSY_WAIT) and fall again.
// Optional feature: define UART_TX_ARB_LOCK_EN to keep ownership with the
// winning requester until it sends a newline or stays silent for
// LOCK_TIMEOUT idle cycles.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int BUSY_WAIT    = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s0_valid,
    input  logic [7:0]       s0_data,
    output logic             s0_ready,
    input  logic             s1_valid,
    input  logic [7:0]       s1_data,
    output logic             s1_ready,
    output logic             uart_we,
    output logic [7:0]       uart_di,
    input  logic             uart_busy,
    output logic [1:0]       grant,
    output logic             active,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam int                WAIT_W    = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT - 1);

    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              uart_we_q, uart_we_d;
    logic [7:0]        uart_di_q, uart_di_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              active_q, active_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;

    logic              elig0_s, elig1_s;
    logic [1:0]        pick_s;
    logic              accept_s;
    logic              win1_s;
    logic [7:0]        acc_data_s;

`ifdef UART_TX_ARB_LOCK_EN
    localparam int                LOCK_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);

    logic              lock_q, lock_d;
    logic              lock_owner_q, lock_owner_d;
    logic [LOCK_W-1:0] lock_idle_q, lock_idle_d;
    logic              owner_valid_s;
`else
    logic              lock_timeout_unused_s;
    assign lock_timeout_unused_s = (LOCK_TIMEOUT > 0);
`endif

    // Requests that may compete this cycle: only in IDLE with the UART free,
    // and, when locked, only from the lock owner.
    always_comb begin
        elig0_s = 1'b0;
        elig1_s = 1'b0;
        if ((state_q == ST_IDLE) && !uart_busy) begin
            elig0_s = s0_valid;
            elig1_s = s1_valid;
`ifdef UART_TX_ARB_LOCK_EN
            if (lock_q) begin
                if (lock_owner_q) begin
                    elig0_s = 1'b0;
                end else begin
                    elig1_s = 1'b0;
                end
            end else begin
                elig0_s = s0_valid;
                elig1_s = s1_valid;
            end
`endif
        end else begin
            elig0_s = 1'b0;
            elig1_s = 1'b0;
        end
    end

    rr_arbiter2 u_rr (
        .req0       (elig0_s),
        .req1       (elig1_s),
        .last_grant (last_grant_q),
        .gnt        (pick_s)
    );

    assign s0_ready   = pick_s[0];
    assign s1_ready   = pick_s[1];
    assign accept_s   = pick_s[0] | pick_s[1];
    assign win1_s     = pick_s[1];
    assign acc_data_s = win1_s ? s1_data : s0_data;

    // Transfer sequencing: accept, strobe, wait for busy to rise then fall.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        uart_we_d    = 1'b0;
        uart_di_d    = uart_di_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        active_d     = active_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d      = ST_ISSUE;
                    uart_we_d    = 1'b1;
                    uart_di_d    = acc_data_s;
                    grant_d      = pick_s;
                    last_grant_d = win1_s;
                    active_d     = 1'b1;
                end else begin
                    active_d     = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (grant_q[1]) begin
                    cnt1_d = sat_inc(cnt1_q);
                end else begin
                    cnt0_d = sat_inc(cnt0_q);
                end
                wait_cnt_d = {WAIT_W{1'b0}};
                state_d    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // A UART that never reports busy is tolerated: give up silently.
                if (uart_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1'b1);
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_busy) begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                end else begin
                    state_d  = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

`ifdef UART_TX_ARB_LOCK_EN
    // Message lock: taken by a winner, dropped on its newline or after a
    // run of idle cycles in which the owner has nothing to send.
    always_comb begin
        owner_valid_s = lock_owner_q ? s1_valid : s0_valid;
        lock_d        = lock_q;
        lock_owner_d  = lock_owner_q;
        lock_idle_d   = {LOCK_W{1'b0}};
        if ((state_q == ST_IDLE) && accept_s) begin
            if (!lock_q) begin
                if (acc_data_s != NEWLINE) begin
                    lock_d       = 1'b1;
                    lock_owner_d = win1_s;
                end else begin
                    lock_d       = 1'b0;
                end
            end else if (acc_data_s == NEWLINE) begin
                lock_d = 1'b0;
            end else begin
                lock_d = 1'b1;
            end
        end else if ((state_q == ST_IDLE) && lock_q && !owner_valid_s) begin
            if (lock_idle_q == LOCK_LAST) begin
                lock_d = 1'b0;
            end else begin
                lock_idle_d = lock_idle_q + LOCK_W'(1'b1);
            end
        end else begin
            lock_idle_d = {LOCK_W{1'b0}};
        end
    end
`endif

    // State and output registers; reset drops any byte in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= {WAIT_W{1'b0}};
            uart_we_q    <= 1'b0;
            uart_di_q    <= 8'h00;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            active_q     <= 1'b0;
            cnt0_q       <= {CNT_W{1'b0}};
            cnt1_q       <= {CNT_W{1'b0}};
`ifdef UART_TX_ARB_LOCK_EN
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            lock_idle_q  <= {LOCK_W{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            uart_we_q    <= uart_we_d;
            uart_di_q    <= uart_di_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            active_q     <= active_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            lock_idle_q  <= lock_idle_d;
`endif
        end
    end

    assign uart_we = uart_we_q;
    assign uart_di = uart_di_q;
    assign grant   = grant_q;
    assign active  = active_q;
    assign cnt0    = cnt0_q;
    assign cnt1    = cnt1_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by
// randomized traffic, all compared every cycle against a transfer-level
// reference model. Honours UART_TX_ARB_LOCK_EN when defined.
module tb_uart_tx_arbiter;

    localparam int BW = 4;
    localparam int LT = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s1_valid;
    logic [7:0]  s0_data, s1_data;
    logic        s0_ready, s1_ready;
    logic        uart_we;
    logic [7:0]  uart_di;
    logic        uart_busy;
    logic [1:0]  grant;
    logic        active;
    logic [15:0] cnt0, cnt1;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.BUSY_WAIT(BW), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
        .uart_we(uart_we), .uart_di(uart_di), .uart_busy(uart_busy),
        .grant(grant), .active(active), .cnt0(cnt0), .cnt1(cnt1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (transfer level) ----------------
    // m_phase: 0 waiting for a byte, 1 strobe cycle, 2 waiting for busy,
    // 3 waiting for busy to drop.
    int         m_phase, m_wait, m_last, m_owner, m_lidle, m_win;
    logic [1:0] m_grant;
    logic [7:0] m_di;
    int         m_cnt0, m_cnt1;
    bit         m_rdy0, m_rdy1, m_we, m_active;

    task automatic model_reset();
        m_phase = 0; m_wait = 0; m_last = 1; m_owner = -1; m_lidle = 0;
        m_grant = 2'b00; m_di = 8'h00; m_cnt0 = 0; m_cnt1 = 0;
    endtask

    task automatic model_comb();
        bit v0, v1;
        if (rst) model_reset();
        m_win = -1;
        if (m_phase == 0 && !uart_busy) begin
            v0 = s0_valid;
            v1 = s1_valid;
            if (m_owner == 0) v1 = 1'b0;
            if (m_owner == 1) v0 = 1'b0;
            if (v0 && v1) m_win = (m_last == 1) ? 0 : 1;
            else if (v0)  m_win = 0;
            else if (v1)  m_win = 1;
        end
        m_rdy0   = (m_win == 0);
        m_rdy1   = (m_win == 1);
        m_we     = (m_phase == 1);
        m_active = (m_phase != 0);
    endtask

    task automatic model_seq();
        int         ph;
        logic [7:0] d;
        if (rst) return;
        ph = m_phase;
        case (m_phase)
            0: begin
                if (m_win >= 0) begin
                    d       = (m_win == 1) ? s1_data : s0_data;
                    m_di    = d;
                    m_grant = (m_win == 0) ? 2'b01 : 2'b10;
                    m_last  = m_win;
                    m_phase = 1;
`ifdef UART_TX_ARB_LOCK_EN
                    if (m_owner < 0) begin
                        if (d != 8'h0A) m_owner = m_win;
                    end else if (d == 8'h0A) begin
                        m_owner = -1;
                    end
                    m_lidle = 0;
`endif
                end else begin
`ifdef UART_TX_ARB_LOCK_EN
                    if (m_owner >= 0) begin
                        if ((m_owner == 0) ? s0_valid : s1_valid) m_lidle = 0;
                        else begin
                            m_lidle++;
                            if (m_lidle == LT) begin
                                m_owner = -1;
                                m_lidle = 0;
                            end
                        end
                    end
`endif
                end
            end
            1: begin
                if (m_grant == 2'b10) m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : 65535;
                else                  m_cnt0 = (m_cnt0 < 65535) ? m_cnt0 + 1 : 65535;
                m_phase = 2;
                m_wait  = 0;
            end
            2: begin
                if (uart_busy) m_phase = 3;
                else begin
                    m_wait++;
                    if (m_wait == BW) m_phase = 3;
                end
            end
            default: if (!uart_busy) m_phase = 0;
        endcase
        if (ph != 0) m_lidle = 0;
    endtask

    // ---------------- UART behaviour and cycle stepping ----------------
    bit         busy_mode, rand_busy;
    int         dly, len, bz_wait, bz_left, bz_len;
    bit         seen_rdy0, seen_rdy1, seen_we, seen_active;
    logic [7:0] seen_di;
    logic [1:0] seen_grant;
    logic [15:0] seen_cnt0, seen_cnt1;
    int         n_we_seen, n_active_seen;
    logic [7:0] log_q[$];
    logic [1:0] glog_q[$];

    task automatic step();
        @(negedge clk);
        model_comb();
        check_eq("s0_ready", s0_ready, m_rdy0);
        check_eq("s1_ready", s1_ready, m_rdy1);
        check_eq("uart_we",  uart_we,  m_we);
        check_eq("active",   active,   m_active);
        check_eq("grant",    grant,    m_grant);
        check_eq("uart_di",  uart_di,  m_di);
        check_eq("cnt0",     cnt0,     m_cnt0);
        check_eq("cnt1",     cnt1,     m_cnt1);
        seen_rdy0 = s0_ready; seen_rdy1 = s1_ready; seen_we = uart_we;
        seen_active = active; seen_di = uart_di; seen_grant = grant;
        seen_cnt0 = cnt0; seen_cnt1 = cnt1;
        if (uart_we) begin
            n_we_seen++;
            log_q.push_back(uart_di);
            glog_q.push_back(grant);
        end
        if (active) n_active_seen++;
        if (m_we && busy_mode) begin
            if (rand_busy) begin
                bz_wait = $urandom_range(1, 7);
                bz_len  = $urandom_range(0, 8);
            end else begin
                bz_wait = dly;
                bz_len  = len;
            end
        end
        model_seq();
        @(posedge clk);
        #1;
        if (bz_wait > 0) begin
            bz_wait--;
            if (bz_wait == 0) bz_left = bz_len;
        end
        uart_busy = (bz_left > 0);
        if (bz_left > 0) bz_left--;
    endtask

    task automatic do_reset();
        rst = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0;
        bz_wait = 0; bz_left = 0; uart_busy = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 200; k++) begin
            step();
            if (!seen_active) break;
        end
        check_eq({tag, "_idle"}, seen_active, 1'b0);
    endtask

    task automatic send(input int who, input logic [7:0] d, input string tag);
        bit acc;
        acc = 1'b0;
        if (who == 0) begin s0_valid = 1'b1; s0_data = d; end
        else          begin s1_valid = 1'b1; s1_data = d; end
        for (int k = 0; k < 50 && !acc; k++) begin
            step();
            acc = (who == 0) ? seen_rdy0 : seen_rdy1;
        end
        check_eq({tag, "_accept"}, acc, 1'b1);
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        wait_idle(tag);
    endtask

`ifdef UART_TX_ARB_LOCK_EN
    logic [7:0] exp_seq [6] = '{8'h30, 8'h31, 8'h32, 8'h61, 8'h62, 8'h63};
    logic [1:0] exp_gnt [6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
`else
    logic [7:0] exp_seq [6] = '{8'h30, 8'h61, 8'h31, 8'h62, 8'h32, 8'h63};
    logic [1:0] exp_gnt [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif

    initial begin
        logic [7:0] q0[$];
        logic [7:0] q1[$];
        int         we0, act0;
        bit         s1_early;

        rst = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0;
        s0_data = 8'h00; s1_data = 8'h00; uart_busy = 1'b0;
        busy_mode = 1'b1; rand_busy = 1'b0; dly = 1; len = 10;
        bz_wait = 0; bz_left = 0; bz_len = 0; n_we_seen = 0; n_active_seen = 0;
        model_reset();

        // Reset values
        step();
        check_eq("rst_grant", seen_grant, 2'b00);
        check_eq("rst_active", seen_active, 1'b0);
        check_eq("rst_di", seen_di, 8'h00);
        step();
        rst = 1'b0;

        // Single byte right after reset release
        s0_valid = 1'b1; s0_data = 8'h41;
        step();
        check_eq("t1_ready", seen_rdy0, 1'b1);
        s0_valid = 1'b0;
        step();
        check_eq("t1_we", seen_we, 1'b1);
        check_eq("t1_di", seen_di, 8'h41);
        repeat (11) step();
        check_eq("t1_active_busy_fell", seen_active, 1'b1);
        step();
        check_eq("t1_active_low", seen_active, 1'b0);
        check_eq("t1_cnt0", seen_cnt0, 16'd1);

        // Contention, both requesters valid continuously
        do_reset();
        dly = 1; len = 3;
        log_q.delete(); glog_q.delete();
        q0 = '{8'h30, 8'h31, 8'h32};
        q1 = '{8'h61, 8'h62, 8'h63};
        for (int k = 0; k < 300 && (q0.size() > 0 || q1.size() > 0); k++) begin
            s0_valid = (q0.size() > 0); s0_data = (q0.size() > 0) ? q0[0] : 8'h00;
            s1_valid = (q1.size() > 0); s1_data = (q1.size() > 0) ? q1[0] : 8'h00;
            step();
            if (seen_rdy0) void'(q0.pop_front());
            if (seen_rdy1) void'(q1.pop_front());
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        wait_idle("t2");
        check_eq("t2_count", log_q.size(), 6);
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            check_eq($sformatf("t2_byte%0d", i), log_q[i], exp_seq[i]);
            check_eq($sformatf("t2_grant%0d", i), glog_q[i], exp_gnt[i]);
        end

        // Busy never rises: bounded wait, no error
        do_reset();
        busy_mode = 1'b0;
        we0 = n_we_seen; act0 = n_active_seen;
        send(1, 8'h55, "t3");
        check_eq("t3_we_count", n_we_seen - we0, 1);
        check_eq("t3_active_cycles", n_active_seen - act0, 2 + BW);
        check_eq("t3_cnt1", seen_cnt1, 16'd1);
        busy_mode = 1'b1;

        // Reset while waiting for the UART to finish
        do_reset();
        dly = 1; len = 30;
        s0_valid = 1'b1; s0_data = 8'h5A;
        for (int k = 0; k < 20 && !seen_rdy0; k++) step();
        s0_valid = 1'b0;
        for (int k = 0; k < 20 && m_phase != 3; k++) step();
        check_eq("t4_reached_wait_done", m_phase, 3);
        rst = 1'b1;
        step();
        check_eq("t4_we", seen_we, 1'b0);
        check_eq("t4_grant", seen_grant, 2'b00);
        check_eq("t4_di", seen_di, 8'h00);
        check_eq("t4_active", seen_active, 1'b0);
        check_eq("t4_cnt0", seen_cnt0, 16'd0);
        rst = 1'b0;
        we0 = n_we_seen;
        repeat (40) step();
        check_eq("t4_no_strobe", n_we_seen - we0, 0);

        // Counter saturation
        do_reset();
        dly = 1; len = 2;
        force dut.cnt0_q = 16'hFFFE;
        m_cnt0 = 16'hFFFE;
        step();
        release dut.cnt0_q;
        for (int i = 0; i < 3; i++) begin
            send(0, 8'h40 + 8'(i), "t5");
            check_eq($sformatf("t5_cnt0_%0d", i), seen_cnt0, 16'hFFFF);
        end

`ifdef UART_TX_ARB_LOCK_EN
        // Locked message "AB\n" ahead of a waiting monitor byte
        do_reset();
        dly = 1; len = 3;
        log_q.delete();
        q0 = '{8'h41, 8'h42, 8'h0A};
        s1_early = 1'b0;
        for (int k = 0; k < 300 && q0.size() > 0; k++) begin
            s0_valid = 1'b1; s0_data = q0[0];
            s1_valid = 1'b1; s1_data = 8'h77;
            step();
            if (seen_rdy1) s1_early = 1'b1;
            if (seen_rdy0) void'(q0.pop_front());
        end
        s0_valid = 1'b0;
        for (int k = 0; k < 100 && !seen_rdy1; k++) step();
        s1_valid = 1'b0;
        wait_idle("t6");
        check_eq("t6_s1_blocked", s1_early, 1'b0);
        check_eq("t6_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            check_eq("t6_b0", log_q[0], 8'h41);
            check_eq("t6_b1", log_q[1], 8'h42);
            check_eq("t6_b2", log_q[2], 8'h0A);
            check_eq("t6_b3", log_q[3], 8'h77);
        end
`endif

        // Randomized traffic with random UART timing and rare resets
        do_reset();
        rand_busy = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c < 1500) begin
                s0_valid = 1'($urandom_range(0, 1));
                s1_valid = 1'($urandom_range(0, 1));
            end else begin
                s0_valid = ($urandom_range(0, 7) == 0);
                s1_valid = ($urandom_range(0, 7) == 0);
            end
            s0_data = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
            s1_data = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
            rst     = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
        wait_idle("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: BUSY_WAIT, default 4, max cycles to wait for uart_busy to rise after a write strobe.
REQ-002 Parameter: LOCK_TIMEOUT, default 1024, idle cycles before a message lock is released (lock feature only).
REQ-003 clk  input  1  clock, all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s0_valid  input  1  requester 0 (CPU) byte available.
REQ-006 s0_data  input  8  requester 0 byte.
REQ-007 s0_ready  output  1  requester 0 byte accepted this cycle when s0_valid is also high.
REQ-008 s1_valid  input  1  requester 1 (debug monitor) byte available.
REQ-009 s1_data  input  8  requester 1 byte.
REQ-010 s1_ready  output  1  requester 1 byte accepted this cycle when s1_valid is also high.
REQ-011 uart_we  output  1  single-cycle write strobe to the UART transmitter.
REQ-012 uart_di  output  8  byte to the UART, stable from strobe until return to IDLE.
REQ-013 uart_busy  input  1  UART transmitter busy, synchronous to clk.
REQ-014 grant  output  2  one-hot owner of the current or last transfer; 2'b00 after reset.
REQ-015 active  output  1  high in every state except IDLE.
REQ-016 cnt0, cnt1  output  16 each  bytes sent per requester, saturating at 16'hFFFF.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-018 IDLE: s0_ready and s1_ready are low whenever uart_busy is high.
REQ-019 IDLE, only one valid: that requester gets ready=1.
REQ-020 IDLE, both valid: ready goes to the requester not in last_grant, giving round-robin.
REQ-021 IDLE, both valid, first contest after reset: s0 wins.
REQ-022 At most one ready is high per cycle; a ready is never high without its own valid.
REQ-023 On acceptance in cycle N: data is captured into uart_di, grant/last_grant update, and the FSM enters ISSUE at N+1.
REQ-024 ISSUE: uart_we=1 for exactly one cycle (N+1), the owner's counter increments with saturation, then go to WAIT_BUSY.
REQ-025 WAIT_BUSY: go to WAIT_DONE when uart_busy=1, or after BUSY_WAIT cycles without it (timeout, no error).
REQ-026 WAIT_DONE: return to IDLE on the first cycle uart_busy=0.
REQ-027 Minimum spacing between two uart_we pulses is 4 cycles.
REQ-028 uart_we is never asserted outside ISSUE.
REQ-029 Counters never wrap.

Reset
REQ-030 rst asserted (any state, including mid-transfer):
 - FSM goes to IDLE, and any captured byte is discarded, never sent.
 - uart_we=0, uart_di=8'h00, grant=2'b00, last_grant=requester 1 (so s0 wins the next contest).
 - Both ready=0 and active=0; cnt0=cnt1=0.
 - Lock state, if compiled in, is cleared.
REQ-031 First acceptance is possible in the first clk edge after rst deasserts.

Configuration
REQ-032 Macro UART_TX_ARB_LOCK_EN: lock is compiled in.
 - After a requester wins, it keeps exclusive ownership across bytes.
 - Lock releases after that requester sends byte 8'h0A, or after LOCK_TIMEOUT consecutive IDLE cycles without its valid.
 - While locked, the other requester's ready stays 0 even if it is valid.
REQ-033 Without UART_TX_ARB_LOCK_EN: arbitration is per byte as in REQ-019 to REQ-022; the LOCK_TIMEOUT parameter is accepted but unused.

Structure
REQ-034 Shared package uart_arb_pkg holds:
 - the FSM state encoding (2 bits);
 - the newline constant 8'h0A;
 - the counter width constant 16.
REQ-035 One sub-module, rr_arbiter2: combinational 2-way round-robin pick from two valids plus last_grant, producing a one-hot grant.

Verification
REQ-036 Single byte: after reset, s0_valid=1, s0_data=8'h41 held one cycle; uart_busy rises 1 cycle after the strobe and holds 10 cycles -> s0_ready=1 at N, uart_we=1 at N+1 with uart_di=8'h41, active low 1 cycle after busy falls, cnt0=1.
REQ-037 Contention (no lock): both valid continuously, s0 bytes 8'h30..8'h32, s1 bytes 8'h61..8'h63 -> UART sequence 30,61,31,62,32,63; grant alternates 01,10.
REQ-038 Busy timeout: uart_busy tied 0, one s1 byte 8'h55 -> WAIT_BUSY exits after 4 cycles, FSM returns to IDLE, cnt1=1, exactly one uart_we.
REQ-039 Mid-operation reset: rst pulsed while in WAIT_DONE -> uart_we stays 0, all outputs at reset values next cycle, and no strobe for the discarded byte.
REQ-040 Saturation: force cnt0 to 16'hFFFE, send 3 s0 bytes -> cnt0 reads FFFF, FFFF, FFFF.
REQ-041 Lock (UART_TX_ARB_LOCK_EN): s0 sends "AB\n" while s1 is valid throughout -> UART sequence 41,42,0A before any s1 byte; s1_ready=0 until 0A is accepted.
